stdcore_bfifo_ctrl: RTL and testbench
=====================================

// Module: stdcore_bfifo_ctrl
// PURPOSE
//  Block-level sequencer for a block FIFO (push/pull-by-block, random access inside a block).
//  Converts a streaming valid/ready producer into aligned in-block writes plus a block commit.
//  Converts block read requests from a consumer into sequential in-block reads plus a block release.
//  Sits between the producing and consuming pipeline stages and the block FIFO instance.
// PARAMETERS
//  DW     1  data width
//  AW     1  in-block address width; block sizes are AW+1 bits wide
//  DEPTH  1  FIFO depth; every block size used must divide DEPTH
// PORTS
//  clk        in   1     clock
//  arst_n     in   1     asynchronous reset, active-low
//  rst_n      in   1     synchronous clear, active-low; shared with the FIFO instance
//  s_valid    in   1     producer beat valid
//  s_ready    out  1     producer beat accepted when s_valid&s_ready
//  s_data     in   DW    producer data
//  s_blk      in   AW+1  block size; held stable while s_valid is high in idle
//  f_p        out  DW    FIFO write data (= s_data)
//  f_p_waddr  out  AW    FIFO in-block write address
//  f_p_we_n   out  1     FIFO write enable, active-low
//  f_p_pblk   out  AW+1  FIFO push-commit size; 0 when idle
//  f_p_vc     in   AW+1  FIFO vacancy
//  m_req      in   1     consumer block request
//  m_blk      in   AW+1  requested block size
//  m_ack      out  1     1-cycle pulse: request accepted, reads start next cycle
//  m_valid    out  1     read data valid
//  m_data     out  DW    read data (= f_c)
//  m_last     out  1     last beat of block
//  f_c        in   DW    FIFO read data
//  f_c_raddr  out  AW    FIFO in-block read address
//  f_c_re_n   out  1     FIFO read enable, active-low
//  f_c_pblk   out  AW+1  FIFO pull-release size; 0 when idle
//  f_c_st     in   AW+1  FIFO stock
//  err        out  2     sticky errors {pull, push}; tied 0 without the macro
// BEHAVIOUR
//  Reset (arst_n or rst_n low): both FSMs IDLE, counters 0. Outputs: s_ready=0, f_p_we_n=1,
//   f_c_re_n=1, pblk=0, m_ack=m_valid=m_last=0, err=0. A partial block is discarded, no commit.
//  Push FSM P_IDLE/P_FILL/P_COMMIT:
//   IDLE: s_valid && s_blk!=0 && f_p_vc>=s_blk -> latch blk, cnt=0, go FILL. Otherwise stay.
//   FILL: s_ready=1; f_p_we_n=~s_valid; f_p_waddr=cnt (combinational).
//    On each beat cnt++. On the beat with cnt==blk-1 -> COMMIT.
//   COMMIT: f_p_pblk=blk for exactly 1 cycle, s_ready=0 -> IDLE.
//    The FIFO vacancy is updated by the next IDLE check.
//   Block period is minimum blk+2 cycles.
//  Pull FSM C_IDLE/C_READ/C_COMMIT:
//   IDLE: m_req && m_blk!=0 && f_c_st>=m_blk -> m_ack pulse, latch blk, go READ.
//   READ: f_c_re_n=0; f_c_raddr=cnt; cnt++ every cycle (no stall). At cnt==blk-1 -> COMMIT.
//   COMMIT: f_c_pblk=blk for 1 cycle -> IDLE.
//   m_valid/m_last are the read strobe/last flag delayed by 1 registered stage; m_data=f_c.
//   The last beat is therefore valid in the COMMIT cycle.
//  Push and pull are independent; both commits may pulse in the same cycle.
//   The FIFO nets both updates in that cycle.
//  Stale f_p_vc/f_c_st are always conservative, so no overcommit is possible.
//  Request/block sizes above DEPTH are never granted and the FSM stays in IDLE.
//   The caller owns this case; the macro flags it.
//  Size comparisons are unsigned, AW+1 bits wide.
// CONFIGURATION
//  STDCORE_BFIFO_CTRL_ERRCHK_EN defined:
//   err[0] sets on s_valid in IDLE with s_blk==0 or s_blk>DEPTH, or s_blk not dividing DEPTH.
//   err[1] is the same check for m_req/m_blk.
//   Errors are sticky until reset; the offending request is not granted.
//   Simulation also $displays each error.
//  Undefined: no checks; err=0; zero-size requests are ignored.
// STRUCTURE
//  Shared package stdcore_bfifo_ctrl_pkg: FSM state encodings, COMMIT/IDLE constants.
//  Sub-module stdcore_bfifo_blkcnt: latch size, count 0..blk-1, terminal flag.
//   Instanced once per side.
// TESTING (DW=8, AW=3, DEPTH=8)
//  1. f_p_vc=8, push s_blk=4, data 0x10..0x13 back-to-back
//     -> waddr 0,1,2,3 with we_n=0, then f_p_pblk=4 for 1 cycle.
//  2. f_p_vc=2, s_blk=4 -> s_ready=0, no writes.
//     Raise f_p_vc=8 -> FILL begins the following cycle.
//  3. f_c_st=4, m_req m_blk=2 -> m_ack; raddr 0,1; m_valid cycles +1,+2; m_last on 2nd;
//     f_c_pblk=2 for 1 cycle.
//  4. Push and pull of 4 timed to end together -> f_p_pblk=4 and f_c_pblk=4 in the same cycle;
//     no lost beats.
//  5. rst_n low after 2 of 4 beats -> s_ready=0 next cycle, no pblk.
//     Next block restarts at waddr 0.
//  6. Macro on, s_blk=0 then m_blk=9 -> err=2'b11 sticky, no grants.
//     Macro off -> err=0, zero-size requests ignored.

Source files
------------

// File: rtl/stdcore_bfifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stdcore_bfifo_ctrl_pkg
// Shared definitions for the block FIFO sequencer:
//   - push / pull FSM state encodings
//   - idle levels of the active-low FIFO strobes
//   - blk_size_allowed(): legality of one candidate block size against DEPTH
// No ports (package).
// -----------------------------------------------------------------------------
package stdcore_bfifo_ctrl_pkg;

   typedef enum logic [1:0] {
      P_IDLE   = 2'd0,
      P_FILL   = 2'd1,
      P_COMMIT = 2'd2
   } push_state_e;

   typedef enum logic [1:0] {
      C_IDLE   = 2'd0,
      C_READ   = 2'd1,
      C_COMMIT = 2'd2
   } pull_state_e;

   // Inactive level of the active-low FIFO write / read strobes
   localparam logic LP_WE_N_IDLE = 1'b1;
   localparam logic LP_RE_N_IDLE = 1'b1;
   // Active level of the same strobes
   localparam logic LP_STROBE_ON = 1'b0;

   // A size is usable when it is non-zero, fits the FIFO and (optionally)
   // tiles the FIFO exactly. Only ever called with constant blk, so it folds.
   function automatic logic blk_size_allowed(input int unsigned depth,
                                             input int unsigned blk,
                                             input logic        chk_div);
      logic ok;
      ok = (blk != 32'd0) && (blk <= depth);
      if (ok && chk_div) begin
         ok = ((depth % blk) == 32'd0);
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

endpackage

// File: rtl/stdcore_bfifo_blkcnt.sv
// -----------------------------------------------------------------------------
// stdcore_bfifo_blkcnt
// Per-side block tracker: latches the granted block size and counts beats
// 0..blk-1, flagging the terminal beat.
// Ports:
//   clk, arst_n  clock, asynchronous active-low reset
//   i_clr        synchronous clear (counter and size to 0)
//   i_load       latch i_blk, restart count at 0
//   i_blk        block size to latch (AW+1 bits)
//   i_inc        advance the beat counter
//   o_cnt        in-block address (AW bits)
//   o_blk        latched block size
//   o_term       current count is the last beat of the block
// -----------------------------------------------------------------------------
module stdcore_bfifo_blkcnt #(
   parameter int AW = 1
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          i_clr,
   input  logic          i_load,
   input  logic [AW:0]   i_blk,
   input  logic          i_inc,
   output logic [AW-1:0] o_cnt,
   output logic [AW:0]   o_blk,
   output logic          o_term
);

   logic [AW:0] r_cnt;
   logic [AW:0] r_blk;

   // Size latch and beat counter
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_cnt <= {(AW+1){1'b0}};
         r_blk <= {(AW+1){1'b0}};
      end else if (i_clr) begin
         r_cnt <= {(AW+1){1'b0}};
         r_blk <= {(AW+1){1'b0}};
      end else if (i_load) begin
         r_cnt <= {(AW+1){1'b0}};
         r_blk <= i_blk;
      end else if (i_inc) begin
         r_cnt <= r_cnt + {{AW{1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt  = r_cnt[AW-1:0];
   assign o_blk  = r_blk;
   assign o_term = (r_cnt == (r_blk - {{AW{1'b0}}, 1'b1}));

endmodule

// File: rtl/stdcore_bfifo_ctrl.sv
// -----------------------------------------------------------------------------
// stdcore_bfifo_ctrl
// Block-level sequencer for a block FIFO. The push side turns a valid/ready
// stream into in-block writes followed by a one-cycle push commit; the pull
// side turns a consumer block request into sequential in-block reads
// followed by a one-cycle pull release. The two sides run independently.
//
// Optional feature macro: STDCORE_BFIFO_CTRL_ERRCHK_EN
//   defined   : illegal sizes (0, >DEPTH, not dividing DEPTH) raise sticky
//               err bits {pull, push} and are never granted
//   undefined : err tied to 0; sizes of 0 or >DEPTH are simply not granted
//
// Ports:
//   clk, arst_n, rst_n         clock, async reset, sync clear (all active-low)
//   s_valid/s_ready/s_data     producer stream, s_blk = block size
//   f_p, f_p_waddr, f_p_we_n   FIFO write data / in-block address / strobe
//   f_p_pblk                   push commit size (0 when idle), f_p_vc vacancy
//   m_req, m_blk, m_ack        consumer block request / size / accept pulse
//   m_valid, m_data, m_last    consumer read data stream
//   f_c, f_c_raddr, f_c_re_n   FIFO read data / in-block address / strobe
//   f_c_pblk                   pull release size (0 when idle), f_c_st stock
//   err                        sticky {pull, push} size errors
// -----------------------------------------------------------------------------
module stdcore_bfifo_ctrl
   import stdcore_bfifo_ctrl_pkg::*;
#(
   parameter int DW    = 1,
   parameter int AW    = 1,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic [AW:0]   s_blk,
   output logic [DW-1:0] f_p,
   output logic [AW-1:0] f_p_waddr,
   output logic          f_p_we_n,
   output logic [AW:0]   f_p_pblk,
   input  logic [AW:0]   f_p_vc,
   input  logic          m_req,
   input  logic [AW:0]   m_blk,
   output logic          m_ack,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   input  logic [DW-1:0] f_c,
   output logic [AW-1:0] f_c_raddr,
   output logic          f_c_re_n,
   output logic [AW:0]   f_c_pblk,
   input  logic [AW:0]   f_c_st,
   output logic [1:0]    err
);

`ifdef STDCORE_BFIFO_CTRL_ERRCHK_EN
   localparam logic LP_CHK_DIV = 1'b1;
`else
   localparam logic LP_CHK_DIV = 1'b0;
`endif

   // Size legality as a mux over every encodable size; each leg is constant.
   function automatic logic size_ok(input logic [AW:0] blk);
      logic ok;
      ok = 1'b0;
      for (int unsigned k = 32'd1; k < (32'd1 << (AW + 32'd1)); k++) begin
         ok = ok | ((32'(blk) == k) && blk_size_allowed(32'(DEPTH), k, LP_CHK_DIV));
      end
      return ok;
   endfunction

   // Both resets hold the FSMs quiet, including their combinational outputs
   logic        w_run;
   assign w_run = arst_n & rst_n;

   // ---------------------------------------------------------------- push side
   push_state_e r_p_state;
   push_state_e w_p_state_nxt;
   logic        w_p_size_ok;
   logic        w_p_grant;
   logic        w_p_load;
   logic        w_p_inc;
   logic [AW-1:0] w_p_cnt;
   logic [AW:0]   w_p_blk;
   logic          w_p_term;

   assign w_p_size_ok = size_ok(s_blk);
   // Vacancy may lag a commit by a cycle; it only ever understates space
   assign w_p_grant   = s_valid && w_p_size_ok && (f_p_vc >= s_blk);

   stdcore_bfifo_blkcnt #(.AW(AW)) u_p_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .i_clr  (~rst_n),
      .i_load (w_p_load),
      .i_blk  (s_blk),
      .i_inc  (w_p_inc),
      .o_cnt  (w_p_cnt),
      .o_blk  (w_p_blk),
      .o_term (w_p_term)
   );

   // Push FSM state register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_p_state <= P_IDLE;
      end else if (!rst_n) begin
         r_p_state <= P_IDLE;
      end else begin
         r_p_state <= w_p_state_nxt;
      end
   end

   // Push FSM next state and write-side outputs
   always_comb begin
      w_p_state_nxt = r_p_state;
      w_p_load      = 1'b0;
      w_p_inc       = 1'b0;
      s_ready       = 1'b0;
      f_p_we_n      = LP_WE_N_IDLE;
      f_p_pblk      = {(AW+1){1'b0}};
      if (w_run) begin
         case (r_p_state)
            P_IDLE: begin
               if (w_p_grant) begin
                  w_p_state_nxt = P_FILL;
                  w_p_load      = 1'b1;
               end else begin
                  w_p_state_nxt = P_IDLE;
               end
            end
            P_FILL: begin
               s_ready  = 1'b1;
               f_p_we_n = ~s_valid;
               if (s_valid) begin
                  w_p_inc = 1'b1;
                  if (w_p_term) begin
                     w_p_state_nxt = P_COMMIT;
                  end else begin
                     w_p_state_nxt = P_FILL;
                  end
               end else begin
                  w_p_state_nxt = P_FILL;
               end
            end
            P_COMMIT: begin
               f_p_pblk      = w_p_blk;
               w_p_state_nxt = P_IDLE;
            end
            default: begin
               w_p_state_nxt = P_IDLE;
            end
         endcase
      end else begin
         w_p_state_nxt = P_IDLE;
      end
   end

   assign f_p       = s_data;
   assign f_p_waddr = w_p_cnt;

   // ---------------------------------------------------------------- pull side
   pull_state_e r_c_state;
   pull_state_e w_c_state_nxt;
   logic        w_c_size_ok;
   logic        w_c_grant;
   logic        w_c_load;
   logic        w_c_inc;
   logic [AW-1:0] w_c_cnt;
   logic [AW:0]   w_c_blk;
   logic          w_c_term;
   logic          r_m_valid;
   logic          r_m_last;

   assign w_c_size_ok = size_ok(m_blk);
   assign w_c_grant   = m_req && w_c_size_ok && (f_c_st >= m_blk);

   stdcore_bfifo_blkcnt #(.AW(AW)) u_c_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .i_clr  (~rst_n),
      .i_load (w_c_load),
      .i_blk  (m_blk),
      .i_inc  (w_c_inc),
      .o_cnt  (w_c_cnt),
      .o_blk  (w_c_blk),
      .o_term (w_c_term)
   );

   // Pull FSM state register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_c_state <= C_IDLE;
      end else if (!rst_n) begin
         r_c_state <= C_IDLE;
      end else begin
         r_c_state <= w_c_state_nxt;
      end
   end

   // Pull FSM next state and read-side outputs
   always_comb begin
      w_c_state_nxt = r_c_state;
      w_c_load      = 1'b0;
      w_c_inc       = 1'b0;
      m_ack         = 1'b0;
      f_c_re_n      = LP_RE_N_IDLE;
      f_c_pblk      = {(AW+1){1'b0}};
      if (w_run) begin
         case (r_c_state)
            C_IDLE: begin
               if (w_c_grant) begin
                  m_ack         = 1'b1;
                  w_c_load      = 1'b1;
                  w_c_state_nxt = C_READ;
               end else begin
                  w_c_state_nxt = C_IDLE;
               end
            end
            C_READ: begin
               // Consumer cannot stall: one read per cycle until the block ends
               f_c_re_n = LP_STROBE_ON;
               w_c_inc  = 1'b1;
               if (w_c_term) begin
                  w_c_state_nxt = C_COMMIT;
               end else begin
                  w_c_state_nxt = C_READ;
               end
            end
            C_COMMIT: begin
               f_c_pblk      = w_c_blk;
               w_c_state_nxt = C_IDLE;
            end
            default: begin
               w_c_state_nxt = C_IDLE;
            end
         endcase
      end else begin
         w_c_state_nxt = C_IDLE;
      end
   end

   // Read qualifiers trail the strobe by the FIFO's one-cycle read latency
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else begin
         r_m_valid <= (r_c_state == C_READ);
         r_m_last  <= (r_c_state == C_READ) && w_c_term;
      end
   end

   assign m_valid   = r_m_valid;
   assign m_last    = r_m_last;
   assign m_data    = f_c;
   assign f_c_raddr = w_c_cnt;

   // ---------------------------------------------------------------- errors
`ifdef STDCORE_BFIFO_CTRL_ERRCHK_EN
   logic [1:0] r_err;
   logic       w_p_bad;
   logic       w_c_bad;

   assign w_p_bad = w_run && (r_p_state == P_IDLE) && s_valid && !w_p_size_ok;
   assign w_c_bad = w_run && (r_c_state == C_IDLE) && m_req   && !w_c_size_ok;

   // Sticky size-error flags, cleared only by a reset
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_err <= 2'b00;
      end else if (!rst_n) begin
         r_err <= 2'b00;
      end else begin
         r_err <= r_err | {w_c_bad, w_p_bad};
      end
   end

   assign err = r_err;
`else
   assign err = 2'b00;
`endif

endmodule

// File: tb/tb_stdcore_bfifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stdcore_bfifo_ctrl
// Cycle-by-cycle vector bench for stdcore_bfifo_ctrl (DW=8, AW=3, DEPTH=8).
// Each row holds the inputs for one clock cycle and the outputs expected in
// that same cycle. Inputs change on the falling edge, outputs are sampled 1
// time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_stdcore_bfifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

`ifdef STDCORE_BFIFO_CTRL_ERRCHK_EN
   localparam logic ERRCHK = 1'b1;
`else
   localparam logic ERRCHK = 1'b0;
`endif

   logic          clk;
   logic          arst_n;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [AW:0]   s_blk;
   logic [DW-1:0] f_p;
   logic [AW-1:0] f_p_waddr;
   logic          f_p_we_n;
   logic [AW:0]   f_p_pblk;
   logic [AW:0]   f_p_vc;
   logic          m_req;
   logic [AW:0]   m_blk;
   logic          m_ack;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [DW-1:0] f_c;
   logic [AW-1:0] f_c_raddr;
   logic          f_c_re_n;
   logic [AW:0]   f_c_pblk;
   logic [AW:0]   f_c_st;
   logic [1:0]    err;

   stdcore_bfifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_blk     (s_blk),
      .f_p       (f_p),
      .f_p_waddr (f_p_waddr),
      .f_p_we_n  (f_p_we_n),
      .f_p_pblk  (f_p_pblk),
      .f_p_vc    (f_p_vc),
      .m_req     (m_req),
      .m_blk     (m_blk),
      .m_ack     (m_ack),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .f_c       (f_c),
      .f_c_raddr (f_c_raddr),
      .f_c_re_n  (f_c_re_n),
      .f_c_pblk  (f_c_pblk),
      .f_c_st    (f_c_st),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      // inputs
      logic       rst_n;
      logic       sv;
      logic [7:0] sd;
      logic [3:0] sb;
      logic [3:0] vc;
      logic       mq;
      logic [3:0] mb;
      logic [3:0] st;
      logic [7:0] fc;
      // expected outputs
      logic       e_srdy;
      logic       e_wen;
      logic [2:0] e_wa;
      logic [3:0] e_ppb;
      logic       e_ack;
      logic       e_ren;
      logic [2:0] e_ra;
      logic [3:0] e_cpb;
      logic       e_mv;
      logic       e_ml;
      logic [1:0] e_err;
   } vec_t;

   vec_t vq[$];
   vec_t cur;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic row_in(input logic r, input logic sv, input logic [7:0] sd,
                         input logic [3:0] sb, input logic [3:0] vc, input logic mq,
                         input logic [3:0] mb, input logic [3:0] st, input logic [7:0] fc);
      cur.rst_n = r;  cur.sv = sv; cur.sd = sd; cur.sb = sb; cur.vc = vc;
      cur.mq    = mq; cur.mb = mb; cur.st = st; cur.fc = fc;
   endtask

   task automatic row_exp(input logic srdy, input logic wen, input logic [2:0] wa,
                          input logic [3:0] ppb, input logic ack, input logic ren,
                          input logic [2:0] ra, input logic [3:0] cpb, input logic mv,
                          input logic ml, input logic [1:0] e);
      cur.e_srdy = srdy; cur.e_wen = wen; cur.e_wa = wa; cur.e_ppb = ppb;
      cur.e_ack  = ack;  cur.e_ren = ren; cur.e_ra = ra; cur.e_cpb = cpb;
      cur.e_mv   = mv;   cur.e_ml  = ml;  cur.e_err = e;
      vq.push_back(cur);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got 0x%0h, want 0x%0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      logic [1:0] e6a;
      logic [1:0] e6b;
      e6a = ERRCHK ? 2'b01 : 2'b00;
      e6b = ERRCHK ? 2'b11 : 2'b00;

      // ---- 1: push 4 beats 0x10..0x13 with ample vacancy
      row_in(1'b1,1'b1,8'h10,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h10,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h11,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd1,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h12,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd2,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h13,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd3,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd4, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      // ---- 2: vacancy 2 < 4 holds off, then vacancy 8 grants; one stall beat
      row_in(1'b1,1'b1,8'h20,4'd4,4'd2, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h20,4'd4,4'd2, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h20,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h20,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h21,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd1,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h22,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd2,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h23,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd3,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd4, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      // ---- 3: pull of 2; first with stock 1 (refused), then stock 4
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b1,4'd2,4'd1,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b1,4'd2,4'd4,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b1,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b0,4'd0,4'd4,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b0,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b0,4'd0,4'd4,8'hA0); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b0,3'd1,4'd0,1'b1,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b0,4'd0,4'd4,8'hA1); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd2,1'b1,1'b1,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b0,4'd0,4'd2,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      // ---- 4: push 4 and pull 4 started together, commits coincide
      row_in(1'b1,1'b1,8'h30,4'd4,4'd8, 1'b1,4'd4,4'd4,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b1,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h30,4'd4,4'd8, 1'b0,4'd0,4'd4,8'h00); row_exp(1'b1,1'b0,3'd0,4'd0, 1'b0,1'b0,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h31,4'd4,4'd8, 1'b0,4'd0,4'd4,8'hB0); row_exp(1'b1,1'b0,3'd1,4'd0, 1'b0,1'b0,3'd1,4'd0,1'b1,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h32,4'd4,4'd8, 1'b0,4'd0,4'd4,8'hB1); row_exp(1'b1,1'b0,3'd2,4'd0, 1'b0,1'b0,3'd2,4'd0,1'b1,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h33,4'd4,4'd8, 1'b0,4'd0,4'd4,8'hB2); row_exp(1'b1,1'b0,3'd3,4'd0, 1'b0,1'b0,3'd3,4'd0,1'b1,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd4,8'hB3); row_exp(1'b0,1'b1,3'd0,4'd4, 1'b0,1'b1,3'd0,4'd4,1'b1,1'b1,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      // ---- 5: synchronous clear after 2 of 4 beats, next block restarts at 0
      row_in(1'b1,1'b1,8'h40,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h40,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h41,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd1,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b0,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h50,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h50,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h51,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd1,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h52,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd2,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h53,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b1,1'b0,3'd3,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b0,8'h00,4'd4,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd4, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      // ---- 6: zero-size push, oversize pull (9 > DEPTH) never granted
      row_in(1'b1,1'b1,8'h60,4'd0,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,2'b00);
      row_in(1'b1,1'b1,8'h60,4'd0,4'd8, 1'b0,4'd0,4'd0,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,e6a);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b1,4'd9,4'd15,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,e6a);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b0,4'd0,4'd15,8'h00); row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,e6b);
      row_in(1'b1,1'b0,8'h00,4'd0,4'd8, 1'b0,4'd0,4'd0,8'h00);  row_exp(1'b0,1'b1,3'd0,4'd0, 1'b0,1'b1,3'd0,4'd0,1'b0,1'b0,e6b);

      // ---- asynchronous reset state, with a pull request pending
      arst_n = 1'b0; rst_n = 1'b1;
      s_valid = 1'b0; s_data = 8'h00; s_blk = 4'd0; f_p_vc = 4'd8;
      m_req = 1'b1; m_blk = 4'd2; f_c_st = 4'd8; f_c = 8'h00;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_s_ready",  -1, 32'(s_ready),  32'd0);
      chk("rst_we_n",     -1, 32'(f_p_we_n), 32'd1);
      chk("rst_p_pblk",   -1, 32'(f_p_pblk), 32'd0);
      chk("rst_m_ack",    -1, 32'(m_ack),    32'd0);
      chk("rst_re_n",     -1, 32'(f_c_re_n), 32'd1);
      chk("rst_c_pblk",   -1, 32'(f_c_pblk), 32'd0);
      chk("rst_m_valid",  -1, 32'(m_valid),  32'd0);
      chk("rst_m_last",   -1, 32'(m_last),   32'd0);
      chk("rst_err",      -1, 32'(err),      32'd0);
      m_req = 1'b0; m_blk = 4'd0; f_c_st = 4'd0;
      @(negedge clk);
      arst_n = 1'b1;

      // ---- table run
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst_n   = vq[i].rst_n;
         s_valid = vq[i].sv;
         s_data  = vq[i].sd;
         s_blk   = vq[i].sb;
         f_p_vc  = vq[i].vc;
         m_req   = vq[i].mq;
         m_blk   = vq[i].mb;
         f_c_st  = vq[i].st;
         f_c     = vq[i].fc;
         #1;
         chk("s_ready",  i, 32'(s_ready),  32'(vq[i].e_srdy));
         chk("f_p_we_n", i, 32'(f_p_we_n), 32'(vq[i].e_wen));
         if (vq[i].e_wen == 1'b0) begin
            chk("f_p_waddr", i, 32'(f_p_waddr), 32'(vq[i].e_wa));
            chk("f_p",       i, 32'(f_p),       32'(vq[i].sd));
         end else begin
            chk("f_p_pblk_idle_wr", i, 32'(f_p_pblk & {4{~f_p_we_n}}), 32'd0);
         end
         chk("f_p_pblk", i, 32'(f_p_pblk), 32'(vq[i].e_ppb));
         chk("m_ack",    i, 32'(m_ack),    32'(vq[i].e_ack));
         chk("f_c_re_n", i, 32'(f_c_re_n), 32'(vq[i].e_ren));
         if (vq[i].e_ren == 1'b0) begin
            chk("f_c_raddr", i, 32'(f_c_raddr), 32'(vq[i].e_ra));
         end else begin
            chk("f_c_re_n_hold", i, 32'(f_c_re_n), 32'd1);
         end
         chk("f_c_pblk", i, 32'(f_c_pblk), 32'(vq[i].e_cpb));
         chk("m_valid",  i, 32'(m_valid),  32'(vq[i].e_mv));
         chk("m_last",   i, 32'(m_last),   32'(vq[i].e_ml));
         if (vq[i].e_mv == 1'b1) begin
            chk("m_data", i, 32'(m_data), 32'(vq[i].fc));
         end else begin
            chk("m_last_without_valid", i, 32'(m_last), 32'd0);
         end
         chk("err",      i, 32'(err),      32'(vq[i].e_err));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
